// File: rtl/cpu_control_logic.sv
// Multi-cycle control unit for the 16-bit RISC CPU: FETCH/EXEC/MEM sequencing and opcode decode.
// Define CPU_CTRL_HALT_EN to make opcode F stop the machine; otherwise F decodes as NOP.
module cpu_control_logic #(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] Rd,
    output logic [2:0] FS,
    output logic [1:0] PS,
    output logic       MB,
    output logic       MD,
    output logic       RW,
    output logic       MW,
    output logic       BC,
    output logic       BL,
    output logic       IL
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_MEM   = 3'd3;
`ifdef CPU_CTRL_HALT_EN
    localparam logic [2:0] S_HALT  = 3'd4;
`endif

    localparam logic [2:0] FS_ADD   = 3'b000;
    localparam logic [2:0] FS_SUB   = 3'b001;
    localparam logic [2:0] FS_AND   = 3'b010;
    localparam logic [2:0] FS_OR    = 3'b011;
    localparam logic [2:0] FS_XOR   = 3'b100;
    localparam logic [2:0] FS_NOT   = 3'b101;
    localparam logic [2:0] FS_SLT   = 3'b110;
    localparam logic [2:0] FS_PASSB = 3'b111;

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       w_rw_raw;
    logic       w_rd_is_r0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        FS           = FS_ADD;
        PS           = 2'b00;
        MB           = 1'b0;
        MD           = 1'b0;
        w_rw_raw     = 1'b0;
        MW           = 1'b0;
        BC           = 1'b0;
        BL           = 1'b0;
        IL           = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                IL           = 1'b1;
                PS           = 2'b01;
                w_next_state = S_EXEC;
            end
            S_EXEC: begin
                w_next_state = S_FETCH;
                case (opcode)
                    4'h1: begin FS = FS_ADD; w_rw_raw = 1'b1; end
                    4'h2: begin FS = FS_SUB; w_rw_raw = 1'b1; end
                    4'h3: begin FS = FS_AND; w_rw_raw = 1'b1; end
                    4'h4: begin FS = FS_OR;  w_rw_raw = 1'b1; end
                    4'h5: begin FS = FS_XOR; w_rw_raw = 1'b1; end
                    4'h6: begin FS = FS_NOT; w_rw_raw = 1'b1; end
                    4'h7: begin FS = FS_SLT; w_rw_raw = 1'b1; end
                    4'h8: begin FS = FS_ADD; MB = 1'b1; w_rw_raw = 1'b1; end
                    4'h9: begin
                        // Address calculation only; the load writes back in MEM.
                        FS           = FS_ADD;
                        MB           = 1'b1;
                        w_next_state = S_MEM;
                    end
                    4'hA: begin FS = FS_ADD; MB = 1'b1; MW = 1'b1; end
                    4'hB: begin FS = FS_PASSB; PS = 2'b10; BC = 1'b0; end
                    4'hC: begin FS = FS_PASSB; PS = 2'b10; BC = 1'b1; end
                    4'hD: begin FS = FS_PASSB; PS = 2'b11; end
                    4'hE: begin FS = FS_PASSB; PS = 2'b11; BL = 1'b1; w_rw_raw = 1'b1; end
`ifdef CPU_CTRL_HALT_EN
                    4'hF: w_next_state = S_HALT;
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                FS           = FS_ADD;
                MB           = 1'b1;
                MD           = 1'b1;
                w_rw_raw     = 1'b1;
                w_next_state = S_FETCH;
            end
`ifdef CPU_CTRL_HALT_EN
            S_HALT: begin
                w_next_state = S_HALT;
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // R0 is hardwired zero: drop any register write that targets it.
    assign w_rd_is_r0 = R0_ZERO && (Rd == 4'h0);
    assign RW         = w_rw_raw && !w_rd_is_r0;

endmodule

// File: tb/tb_cpu_control_logic.sv
// Scoreboard bench for cpu_control_logic; expectations follow the CPU_CTRL_HALT_EN setting of the build.
module tb_cpu_control_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] Rd;
    logic [2:0] FS;
    logic [1:0] PS;
    logic       MB, MD, RW, MW, BC, BL, IL;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [11:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    cpu_control_logic #(.R0_ZERO(1'b1)) dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .Rd     (Rd),
        .FS     (FS),
        .PS     (PS),
        .MB     (MB),
        .MD     (MD),
        .RW     (RW),
        .MW     (MW),
        .BC     (BC),
        .BL     (BL),
        .IL     (IL)
    );

    always #5 clk = ~clk;

    // Control word packing: {FS, PS, MB, MD, RW, MW, BC, BL, IL}
    function automatic logic [11:0] cw(input logic [2:0] fs, input logic [1:0] ps,
                                       input logic mb, input logic md, input logic rw,
                                       input logic mw, input logic bc, input logic bl,
                                       input logic il);
        return {fs, ps, mb, md, rw, mw, bc, bl, il};
    endfunction

    function automatic logic [11:0] observed();
        return {FS, PS, MB, MD, RW, MW, BC, BL, IL};
    endfunction

    localparam logic [11:0] ZERO    = 12'h000;
    localparam logic [11:0] W_FETCH = {3'b000, 2'b01, 7'b0000001};

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %03h expected %03h (FS,PS,MB,MD,RW,MW,BC,BL,IL)", tag, got, exp);
        end
    endtask

    // Driver: called at posedge+1, sets inputs for this cycle and queues the expected outputs.
    task automatic cycle(input string tag, input logic [3:0] op, input logic [3:0] rd,
                         input logic [11:0] exp);
        sb_entry_t e;
        opcode = op;
        Rd     = rd;
        e.tag  = tag;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input string tag, input logic [3:0] op, input logic [3:0] rd,
                         input logic [11:0] exp);
        cycle({tag, "_fetch"}, op, rd, W_FETCH);
        cycle(tag, op, rd, exp);
    endtask

    // Monitor: compares on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check(e.tag, observed(), e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        opcode = 4'h0;
        Rd     = 4'h0;
        @(posedge clk);
        #1;
        check("reset_outputs", observed(), ZERO);
        #4;
        reset = 1'b0;
        @(posedge clk);
        #1;

        instr("nop", 4'h0, 4'h0, ZERO);
        instr("add_r3", 4'h1, 4'h3, cw(3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        instr("add_r0", 4'h1, 4'h0, ZERO);

        for (int op = 2; op <= 7; op++) begin
            logic [2:0] fs_exp;
            fs_exp = 3'(op - 1);
            instr($sformatf("alu_op%0d", op), 4'(op), 4'h5, cw(fs_exp, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        end
        instr("addi", 4'h8, 4'h6, cw(3'b000, 2'b00, 1, 0, 1, 0, 0, 0, 0));

        instr("ld_exec", 4'h9, 4'h2, cw(3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        cycle("ld_mem", 4'h9, 4'h2, cw(3'b000, 2'b00, 1, 1, 1, 0, 0, 0, 0));
        instr("ld_r0_exec", 4'h9, 4'h0, cw(3'b000, 2'b00, 1, 0, 0, 0, 0, 0, 0));
        cycle("ld_r0_mem", 4'h9, 4'h0, cw(3'b000, 2'b00, 1, 1, 0, 0, 0, 0, 0));

        instr("st", 4'hA, 4'h4, cw(3'b000, 2'b00, 1, 0, 0, 1, 0, 0, 0));
        instr("bz", 4'hB, 4'h1, cw(3'b111, 2'b10, 0, 0, 0, 0, 0, 0, 0));
        instr("bnz", 4'hC, 4'h1, cw(3'b111, 2'b10, 0, 0, 0, 0, 1, 0, 0));
        instr("jmp", 4'hD, 4'h7, cw(3'b111, 2'b11, 0, 0, 0, 0, 0, 0, 0));
        instr("jal_r15", 4'hE, 4'hF, cw(3'b111, 2'b11, 0, 0, 1, 0, 0, 1, 0));
        instr("jal_r0", 4'hE, 4'h0, cw(3'b111, 2'b11, 0, 0, 0, 0, 0, 1, 0));

        instr("op_f", 4'hF, 4'h1, ZERO);
`ifdef CPU_CTRL_HALT_EN
        for (int i = 0; i < 4; i++) cycle($sformatf("halted%0d", i), 4'h0, 4'h0, ZERO);
`else
        instr("after_f", 4'h1, 4'h3, cw(3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0));
`endif

        // Reset pulse, then restart through IDLE.
        reset = 1'b1;
        #1;
        check("reset_pulse", observed(), ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("restart_idle", 4'h0, 4'h0, ZERO);
        instr("restart_nop", 4'h0, 4'h0, ZERO);

        // Asynchronous reset in the middle of an ADD execute cycle.
        cycle("async_fetch", 4'h1, 4'h3, W_FETCH);
        check("async_pre_rw", observed(), cw(3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_drop", observed(), ZERO);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle("async_idle", 4'h1, 4'h3, ZERO);
        instr("async_resume", 4'h1, 4'h3, cw(3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 0));

        @(posedge clk);
        #1;
        check("scoreboard_drained", 12'(sb_q.size()), 12'h000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_logic.md
Name: cpu_control_logic

Overview:
- Multi-cycle control unit for the 16-bit RISC CPU.
- Sequences instruction fetch and execute.
- Decodes the 4-bit opcode held in the instruction register into datapath controls: ALU function, PC select, mux selects, register/memory write enables, branch condition/link and instruction-register load.
- Sits between the instruction register and the datapath/PC unit.

Parameters:
- R0_ZERO, 1, when 1 register-file writes are suppressed whenever Rd==0 (R0 hardwired zero).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- opcode  input  4  opcode field of the instruction register; stable from the cycle after IL until the next IL.
- Rd  input  4  destination register field of the instruction register.
- FS  output  3  ALU function: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SLT, 111 PASSB.
- PS  output  2  PC select: 00 hold, 01 PC+1, 10 conditional relative branch (datapath evaluates flag per BC), 11 absolute jump from register.
- MB  output  1  ALU B mux: 0 register, 1 immediate.
- MD  output  1  writeback mux: 0 ALU result, 1 memory data.
- RW  output  1  register-file write enable.
- MW  output  1  data-memory write enable.
- BC  output  1  branch condition: 0 taken on zero, 1 taken on nonzero.
- BL  output  1  branch-and-link: writeback source is PC (return address).
- IL  output  1  instruction-register load enable.

Behaviour:
- One clock (clk); reset is asynchronous and active-high.
- State register states: IDLE, FETCH, EXEC, MEM, HALT. Reset forces IDLE immediately.
- Outputs are combinational from current state and opcode (Moore/Mealy on the registered IR).
- Every output is 0 in IDLE and HALT, and throughout reset.
- IDLE -> FETCH on the first clk edge after reset deasserts.
- FETCH:
  - IL=1, PS=01; all other outputs 0.
  - Always goes to EXEC.
- EXEC decode by opcode (unlisted outputs 0, PS=00 unless stated):
  - 0 NOP.
  - 1 ADD FS=000 RW=1.
  - 2 SUB FS=001 RW=1.
  - 3 AND FS=010 RW=1.
  - 4 OR FS=011 RW=1.
  - 5 XOR FS=100 RW=1.
  - 6 NOT FS=101 RW=1.
  - 7 SLT FS=110 RW=1.
  - 8 ADDI FS=000 MB=1 RW=1.
  - 9 LD FS=000 MB=1 (address calc), RW=0, next state MEM.
  - A ST FS=000 MB=1 MW=1.
  - B BZ FS=111 PS=10 BC=0.
  - C BNZ FS=111 PS=10 BC=1.
  - D JMP FS=111 PS=11.
  - E JAL FS=111 PS=11 BL=1 RW=1.
  - F HALT, next state HALT.
- EXEC -> FETCH for all opcodes except 9 (-> MEM) and F (-> HALT).
- MEM (LD only): FS=000 MB=1 MD=1 RW=1, then FETCH.
- Latency per instruction:
  - 2 cycles normal (FETCH+EXEC).
  - 3 cycles LD.
  - HALT permanent until reset.
- R0_ZERO=1 and Rd==4'h0: RW forced 0 in EXEC and MEM. All other outputs are unchanged.
- Reset mid-instruction (any state): outputs drop to 0 asynchronously, with no partial writes afterward. Execution restarts at IDLE -> FETCH.
- Opcode changes outside FETCH are not expected. Outputs track opcode combinationally, with no internal opcode latch.
- MW and RW are never both 1. IL is 1 only in FETCH.

Optional Feature:
- Macro CPU_CTRL_HALT_EN.
- Defined: opcode F enters HALT as above.
- Undefined: opcode F decodes as NOP (all EXEC outputs 0, PS=00, next state FETCH). The HALT state is not implemented.

Test Plan:
- Reset held high 10 ns with opcode=0 -> all outputs 0. After release, first edge gives IDLE->FETCH: IL=1 PS=01. Next edge gives EXEC with all outputs 0 (NOP).
- opcode=1 Rd=3 -> EXEC: FS=000 RW=1 MB=0 MD=0. Next cycle IL=1 again. Repeat with Rd=0 -> RW=0.
- opcode=9 Rd=2 -> EXEC: FS=000 MB=1 RW=0. Then MEM: MD=1 RW=1. Then FETCH; 3-cycle period.
- opcode=B then C -> PS=10 with BC=0 / BC=1. opcode=E Rd=15 -> PS=11 BL=1 RW=1. opcode=A -> MW=1 RW=0.
- opcode=F with CPU_CTRL_HALT_EN -> after EXEC, all outputs 0 and IL never asserts again. Then reset pulse -> resumes FETCH.
- Assert reset asynchronously mid-EXEC of ADD (between edges) -> RW drops to 0 immediately, without waiting for a clk edge.
